// File: rtl/hazard_scoreboard_ctrl.sv
// Issue controller beside decode: per-register scoreboard, RAW/WAW stall,
// multi-cycle flush after a taken branch, saturating stall-cycle counter.
module hazard_scoreboard_ctrl #(
    parameter int NREGS        = 32,
    parameter int REG_W        = 5,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_uses_rs1,
    input  logic             id_uses_rs2,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_reg_write,
    input  logic             wb_valid,
    input  logic [REG_W-1:0] wb_rd,
    input  logic             ex_branch_taken,
    output logic             issue,
    output logic             stall_fetch,
    output logic             stall_decode,
    output logic             flush_decode,
    output logic [NREGS-1:0] busy_mask,
    output logic [CNT_W-1:0] stall_count
);

    localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam bit HAS_FLUSH = (FLUSH_CYCLES > 1);

    typedef enum logic {
        RUN,
        FLUSH
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [FC_W-1:0]   fcnt;
    logic [FC_W-1:0]   fcnt_next;
    logic [NREGS-1:0]  busy_eff;
    logic [NREGS-1:0]  busy_next;
    logic              raw;
    logic              waw;
    logic              run;
    logic              hazard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            fcnt  <= '0;
        end else begin
            state <= state_next;
            fcnt  <= fcnt_next;
        end
    end

    // fcnt holds the FLUSH cycles still to come, including the current one
    always_comb begin
        state_next = state;
        fcnt_next  = fcnt;
        unique case (state)
            RUN: begin
                if (ex_branch_taken && HAS_FLUSH) begin
                    state_next = FLUSH;
                    fcnt_next  = FC_W'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                fcnt_next = fcnt - 1'b1;
                if (fcnt == FC_W'(1)) begin
                    state_next = RUN;
                end
            end
            default: begin
                state_next = RUN;
                fcnt_next  = '0;
            end
        endcase
    end

    always_comb begin
        busy_eff = busy_mask;
        if (wb_valid) begin
            busy_eff[wb_rd] = 1'b0;
        end
        busy_eff[0] = 1'b0;
        raw = (id_uses_rs1 & busy_eff[id_rs1])
            | (id_uses_rs2 & busy_eff[id_rs2]);
        waw = id_reg_write & busy_eff[id_rd];
        run = (state == RUN);
        hazard = ~rst & id_valid & (raw | waw) & run & ~ex_branch_taken;
        issue        = ~rst & id_valid & ~hazard & run & ~ex_branch_taken;
        stall_fetch  = hazard;
        stall_decode = hazard;
        flush_decode = ~rst & (ex_branch_taken | (state == FLUSH));
    end

    // set after clear so an issue wins over a same-index writeback
    always_comb begin
        busy_next = busy_mask;
        if (wb_valid) begin
            busy_next[wb_rd] = 1'b0;
        end
        if (issue && id_reg_write && (id_rd != '0)) begin
            busy_next[id_rd] = 1'b1;
        end
        busy_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_mask <= '0;
        end else begin
            busy_mask <= busy_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_count <= '0;
        end else if (hazard && (stall_count != {CNT_W{1'b1}})) begin
            stall_count <= stall_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard_ctrl.sv
// Bench for hazard_scoreboard_ctrl: directed scenarios plus random
// traffic, all checked every cycle against a behavioural model.
module tb_hazard_scoreboard_ctrl;

    localparam int NREGS = 32;
    localparam int REG_W = 5;
    localparam int FC    = 2;
    localparam int CW    = 4;
    localparam int CMAX  = 15;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid;
    logic [REG_W-1:0] id_rs1;
    logic [REG_W-1:0] id_rs2;
    logic             id_uses_rs1;
    logic             id_uses_rs2;
    logic [REG_W-1:0] id_rd;
    logic             id_reg_write;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic             ex_branch_taken;
    logic             issue;
    logic             stall_fetch;
    logic             stall_decode;
    logic             flush_decode;
    logic [NREGS-1:0] busy_mask;
    logic [CW-1:0]    stall_count;

    int checks = 0;
    int failures = 0;

    logic [NREGS-1:0] m_busy = '0;
    int               m_cnt = 0;
    int               m_frem = 0;
    bit               e_iss = 0;
    bit               e_haz = 0;
    bit               e_fl = 0;

    always #5 clk = ~clk;

    hazard_scoreboard_ctrl #(
        .NREGS(NREGS), .REG_W(REG_W), .FLUSH_CYCLES(FC), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write),
        .wb_valid(wb_valid), .wb_rd(wb_rd),
        .ex_branch_taken(ex_branch_taken),
        .issue(issue), .stall_fetch(stall_fetch),
        .stall_decode(stall_decode), .flush_decode(flush_decode),
        .busy_mask(busy_mask), .stall_count(stall_count)
    );

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s t=%0t actual=%0h required=%0h",
                     name, $time, act, exp);
        end
    endtask

    task automatic idle();
        id_valid = 0; id_rs1 = 0; id_rs2 = 0;
        id_uses_rs1 = 0; id_uses_rs2 = 0;
        id_rd = 0; id_reg_write = 0;
        wb_valid = 0; wb_rd = 0; ex_branch_taken = 0;
    endtask

    // Model outputs for the current inputs, compared mid-cycle
    task automatic settle();
        logic [NREGS-1:0] beff;
        bit raw, waw, infl;
        @(negedge clk);
        beff = m_busy;
        if (wb_valid) beff[wb_rd] = 1'b0;
        beff[0] = 1'b0;
        raw = (id_uses_rs1 && beff[id_rs1]) || (id_uses_rs2 && beff[id_rs2]);
        waw = id_reg_write && beff[id_rd];
        infl = (m_frem > 0);
        e_haz = !rst && id_valid && (raw || waw) && !infl && !ex_branch_taken;
        e_iss = !rst && id_valid && !e_haz && !infl && !ex_branch_taken;
        e_fl  = !rst && (ex_branch_taken || infl);
        chk("issue", 64'(issue), 64'(e_iss));
        chk("stall_fetch", 64'(stall_fetch), 64'(e_haz));
        chk("stall_decode", 64'(stall_decode), 64'(e_haz));
        chk("flush_decode", 64'(flush_decode), 64'(e_fl));
        chk("busy_mask", 64'(busy_mask), 64'(m_busy));
        chk("stall_count", 64'(stall_count), 64'(m_cnt));
    endtask

    task automatic advance();
        @(posedge clk);
        if (rst) begin
            m_busy = '0; m_cnt = 0; m_frem = 0;
        end else begin
            if (m_frem > 0) m_frem--;
            else if (ex_branch_taken) m_frem = FC - 1;
            if (wb_valid) m_busy[wb_rd] = 1'b0;
            if (e_iss && id_reg_write && id_rd != 0) m_busy[id_rd] = 1'b1;
            if (e_haz && m_cnt < CMAX) m_cnt++;
        end
        #1;
    endtask

    task automatic cyc();
        settle();
        advance();
    endtask

    initial begin
        idle();
        rst = 1;
        advance();
        cyc();
        rst = 0;
        // busy bit set, then reset held two cycles
        id_valid = 1; id_rd = 3; id_reg_write = 1;
        settle(); chk("t1_issue", 64'(issue), 64'd1); advance();
        idle();
        settle(); chk("t1_busy3", 64'(busy_mask), 64'h8); advance();
        rst = 1;
        id_valid = 1; ex_branch_taken = 1;
        settle();
        chk("t1_rst_issue", 64'(issue), 64'd0);
        chk("t1_rst_flush", 64'(flush_decode), 64'd0);
        advance();
        settle();
        chk("t1_rst_busy", 64'(busy_mask), 64'd0);
        chk("t1_rst_cnt", 64'(stall_count), 64'd0);
        advance();
        rst = 0; idle();
        // RAW stall released by same-cycle writeback
        id_valid = 1; id_rd = 5; id_reg_write = 1;
        settle(); chk("t2_issue_rd5", 64'(issue), 64'd1); advance();
        id_rs1 = 5; id_uses_rs1 = 1; id_rd = 6;
        settle();
        chk("t2_stall_f", 64'(stall_fetch), 64'd1);
        chk("t2_stall_d", 64'(stall_decode), 64'd1);
        chk("t2_no_issue", 64'(issue), 64'd0);
        advance();
        wb_valid = 1; wb_rd = 5;
        settle(); chk("t2_release", 64'(issue), 64'd1); advance();
        idle(); wb_valid = 1; wb_rd = 6;
        cyc();
        // flush length, and a second branch inside FLUSH
        idle(); id_valid = 1; ex_branch_taken = 1;
        settle();
        chk("t3_fl0", 64'(flush_decode), 64'd1);
        chk("t3_iss0", 64'(issue), 64'd0);
        advance();
        ex_branch_taken = 0;
        settle();
        chk("t3_fl1", 64'(flush_decode), 64'd1);
        chk("t3_iss1", 64'(issue), 64'd0);
        advance();
        settle(); chk("t3_fl2", 64'(flush_decode), 64'd0); advance();
        ex_branch_taken = 1; cyc();
        settle(); chk("t3_fl_again", 64'(flush_decode), 64'd1); advance();
        ex_branch_taken = 0;
        settle();
        chk("t3_no_extend", 64'(flush_decode), 64'd0);
        chk("t3_iss_after", 64'(issue), 64'd1);
        advance();
        // set wins over clear on the same index
        idle(); id_valid = 1; id_rd = 7; id_reg_write = 1;
        cyc();
        wb_valid = 1; wb_rd = 7;
        settle(); chk("t4_issue", 64'(issue), 64'd1); advance();
        idle();
        settle(); chk("t4_busy7", 64'(busy_mask[7]), 64'd1); advance();
        wb_valid = 1; wb_rd = 7; cyc();
        // x0 is never tracked and never stalls
        idle(); id_valid = 1; id_rd = 0; id_reg_write = 1;
        cyc();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 1; id_uses_rs2 = 1;
        settle();
        chk("t5_busy0", 64'(busy_mask), 64'd0);
        chk("t5_x0_nostall", 64'(stall_fetch), 64'd0);
        advance();
        // long hazard saturates the counter
        idle(); id_valid = 1; id_rd = 10; id_reg_write = 1;
        cyc();
        id_rd = 0; id_reg_write = 0; id_rs1 = 10; id_uses_rs1 = 1;
        for (int i = 0; i < 20; i++) cyc();
        settle(); chk("t6_sat", 64'(stall_count), 64'd15); advance();
        rst = 1;
        settle(); chk("t6_rst_stall", 64'(stall_fetch), 64'd0); advance();
        settle(); chk("t6_rst_cnt", 64'(stall_count), 64'd0); advance();
        rst = 0;
        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 63) == 0);
            id_valid = ($urandom_range(0, 3) != 0);
            id_rs1 = REG_W'($urandom_range(0, 7));
            id_rs2 = REG_W'($urandom_range(0, 7));
            id_uses_rs1 = 1'($urandom);
            id_uses_rs2 = 1'($urandom);
            id_rd = REG_W'($urandom_range(0, 7));
            id_reg_write = 1'($urandom);
            wb_valid = ($urandom_range(0, 2) == 0);
            wb_rd = REG_W'($urandom_range(0, 7));
            ex_branch_taken = ($urandom_range(0, 11) == 0);
            cyc();
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
